// File: rtl/gspram_access_seq_if.sv
// gspram_access_seq_if
//   Bundles the request/response handshake and the GSPRAM macro pins
//   around gspram_access_seq.
//   slave  : the sequencer view (accepts requests, drives the macro pins).
//   master : the environment view (requester plus the macro that returns ram_rda).
//   Request  : req_valid, req_ready, req_wr, req_adr[AW], req_wda[DW]
//   Response : rsp_valid, rsp_ready, rsp_rda[DW]
//   Macro    : ram_ena, ram_wri, ram_adr[AW], ram_wda[DW], ram_rda[DW]
interface gspram_access_seq_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_wda;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rda;
  logic          ram_ena;
  logic          ram_wri;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_wda;
  logic [DW-1:0] ram_rda;

  modport slave (
    input  req_valid, req_wr, req_adr, req_wda, rsp_ready, ram_rda,
    output req_ready, rsp_valid, rsp_rda, ram_ena, ram_wri, ram_adr, ram_wda
  );

  modport master (
    output req_valid, req_wr, req_adr, req_wda, rsp_ready, ram_rda,
    input  req_ready, rsp_valid, rsp_rda, ram_ena, ram_wri, ram_adr, ram_wda
  );
endinterface

// File: rtl/gspram_access_seq.sv
// gspram_access_seq
//   Sequencer in front of a 256x32 single-port GSPRAM macro. Turns a
//   valid/ready read/write request stream into the macro's ena pulse
//   protocol (read samples on ena rise, write commits on ena fall, adr/wri
//   stable while ena is high) and returns read data on a valid/ready port.
// Ports
//   clk    : system clock, all state changes on posedge
//   rst_n  : synchronous active-low reset
//   bus    : gspram_access_seq_if.slave (request, response and macro pins)
// Timing per access: SETUP_CYC clocks with ena low, ENA_HI_CYC clocks with
// ena high, ENA_LO_CYC clocks of recovery with ena low, then back to idle.
module gspram_access_seq #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int SETUP_CYC  = 1,
  parameter int ENA_HI_CYC = 2,
  parameter int ENA_LO_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gspram_access_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACT, REC} state_t;

  // Counter reload values: each phase lasts (load + 1) clocks.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HI_LD    = 8'(ENA_HI_CYC - 1);
  localparam logic [7:0] LO_LD    = 8'(ENA_LO_CYC - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       ena_next;
  logic       accept;
  logic       capture;

  // A pending response blocks new requests of either kind, and nothing is
  // accepted while reset is asserted.
  assign bus.req_ready = rst_n & (state == IDLE) & ~bus.rsp_valid;
  assign accept        = bus.req_valid & bus.req_ready;

  // State register; ena is registered here so the macro sees a glitch-free pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      bus.ram_ena <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bus.ram_ena <= ena_next;
    end
  end

  // Next-state logic: one down-counter, reloaded on every phase entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ena_next   = bus.ram_ena;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_next = ACT;
          cnt_next   = HI_LD;
          ena_next   = 1'b1;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ACT: begin
        if (cnt == 8'd0) begin
          state_next = REC;
          cnt_next   = LO_LD;
          ena_next   = 1'b0;
          // Read data has been valid since the ena rise plus access time.
          capture    = ~bus.ram_wri;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      REC: begin
        if (cnt == 8'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        ena_next   = 1'b0;
      end
    endcase
  end

  // Macro address/control/data. These are cleared on reset only once ena is
  // already low, so an access cut short by reset still sees a clean ena fall
  // with unchanged adr/wri (an aborted write therefore still commits).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (!bus.ram_ena) begin
        bus.ram_adr <= {AW{1'b0}};
        bus.ram_wri <= 1'b0;
        bus.ram_wda <= {DW{1'b0}};
      end
    end else if (accept) begin
      bus.ram_adr <= bus.req_adr;
      bus.ram_wri <= bus.req_wr;
      bus.ram_wda <= bus.req_wda;
    end
  end

  // Read response holding register; stays stable until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rda   <= {DW{1'b0}};
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rda   <= bus.ram_rda;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gspram_access_seq.sv
// tb_gspram_access_seq
//   Directed bench for gspram_access_seq with a behavioural 256x32 macro
//   model (read on ena rise, write on ena fall). Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_gspram_access_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  gspram_access_seq_if #(.AW(8), .DW(32)) bus ();

  gspram_access_seq #(
    .AW(8), .DW(32), .SETUP_CYC(1), .ENA_HI_CYC(2), .ENA_LO_CYC(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: sample on ena rise, commit on ena fall.
  logic [31:0] mem [256];
  always @(posedge bus.ram_ena) if (!bus.ram_wri) bus.ram_rda = mem[bus.ram_adr];
  always @(negedge bus.ram_ena) if (bus.ram_wri) mem[bus.ram_adr] = bus.ram_wda;

  // Protocol monitor: adr/wri must not move while ena is high; counts ena
  // pulses and pulses whose high time is not exactly 2 clocks.
  logic        prev_ena;
  logic        prev_wri;
  logic [7:0]  prev_adr;
  int          mon_err;
  int          pulses;
  int          bad_len;
  int          hi_len;
  logic [31:0] last_rsp;
  initial begin
    prev_ena = 1'b0; prev_wri = 1'b0; prev_adr = 8'h00;
    mon_err = 0; pulses = 0; bad_len = 0; hi_len = 0; last_rsp = 32'h0;
  end
  always @(negedge clk) begin
    if (bus.ram_ena && prev_ena && (bus.ram_adr !== prev_adr || bus.ram_wri !== prev_wri))
      mon_err = mon_err + 1;
    if (bus.ram_ena && !prev_ena) pulses = pulses + 1;
    if (bus.ram_ena) hi_len = hi_len + 1;
    else begin
      if (prev_ena && hi_len != 2) bad_len = bad_len + 1;
      hi_len = 0;
    end
    if (bus.rsp_valid && bus.rsp_ready) last_rsp = bus.rsp_rda;
    prev_ena = bus.ram_ena;
    prev_wri = bus.ram_wri;
    prev_adr = bus.ram_adr;
  end

  task automatic send(input logic wr, input logic [7:0] adr, input logic [31:0] wda,
                      output int acc);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_adr   = adr;
    bus.req_wda   = wda;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL send_timeout adr=%h: req_ready got %b want 1", adr, bus.req_ready);
      bus.req_valid = 1'b0;
      acc = -1;
    end else begin
      @(negedge clk);
      acc = cyc;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] adr, input logic [31:0] exp, input string name);
    int acc;
    int n;
    send(1'b0, adr, 32'h0, acc);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (cyc - acc !== 3 || !bus.rsp_valid) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: got %0d clocks (valid=%b) want 3", name, cyc - acc, bus.rsp_valid);
    end
    n_cmp++;
    if (bus.rsp_rda !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s_data: got %h want %h", name, bus.rsp_rda, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rda !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rda: got %h want 0", bus.rsp_rda); end
    n_cmp++; if (bus.ram_ena !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_ena: got %b want 0", bus.ram_ena); end
    n_cmp++; if (bus.ram_wri !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_wri: got %b want 0", bus.ram_wri); end
    n_cmp++; if (bus.ram_adr !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_ram_adr: got %h want 0", bus.ram_adr); end
    n_cmp++; if (bus.ram_wda !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ram_wda: got %h want 0", bus.ram_wda); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    int acc;
    send(1'b1, 8'h00, 32'hDEADBEEF, acc);
    do_read(8'h00, 32'hDEADBEEF, "t1_read00");
  endtask

  task automatic test_boundary_addr();
    int acc;
    send(1'b1, 8'hFF, 32'h12345678, acc);
    send(1'b1, 8'h01, 32'h00000000, acc);
    do_read(8'hFF, 32'h12345678, "t2_readFF");
    do_read(8'h01, 32'h00000000, "t2_read01");
  endtask

  task automatic test_back_to_back();
    logic        wr_t  [4];
    logic [7:0]  adr_t [4];
    logic [31:0] wda_t [4];
    int          acc   [4];
    int          p0, b0, n;
    wr_t[0] = 1'b1; adr_t[0] = 8'h10; wda_t[0] = 32'h11111111;
    wr_t[1] = 1'b0; adr_t[1] = 8'h10; wda_t[1] = 32'h0;
    wr_t[2] = 1'b1; adr_t[2] = 8'h20; wda_t[2] = 32'h22222222;
    wr_t[3] = 1'b0; adr_t[3] = 8'h20; wda_t[3] = 32'h0;
    @(negedge clk);
    p0 = pulses; b0 = bad_len;
    bus.req_valid = 1'b1;
    bus.req_wr = wr_t[0]; bus.req_adr = adr_t[0]; bus.req_wda = wda_t[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus.req_ready && n < 30) begin @(negedge clk); n++; end
      @(negedge clk);
      acc[i] = cyc;
      if (i < 3) begin
        bus.req_wr = wr_t[i+1]; bus.req_adr = adr_t[i+1]; bus.req_wda = wda_t[i+1];
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (acc[i] - acc[i-1] !== 6) begin
        n_fail++;
        $display("[TB] FAIL t3_spacing%0d: got %0d clocks want 6", i, acc[i] - acc[i-1]);
      end
    end
    n_cmp++; if (pulses - p0 !== 4) begin n_fail++; $display("[TB] FAIL t3_pulses: got %0d want 4", pulses - p0); end
    n_cmp++; if (bad_len - b0 !== 0) begin n_fail++; $display("[TB] FAIL t3_ena_width: got %0d bad pulses want 0", bad_len - b0); end
    n_cmp++; if (last_rsp !== 32'h22222222) begin n_fail++; $display("[TB] FAIL t3_last_rsp: got %h want 22222222", last_rsp); end
  endtask

  task automatic test_rsp_stall();
    int acc, n;
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h10, 32'h0, acc);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_adr = 8'h30; bus.req_wda = 32'h33333333;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rda !== 32'h11111111 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL t4_hold%0d: got valid=%b rda=%h ready=%b want 1/11111111/0",
                 i, bus.rsp_valid, bus.rsp_rda, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_adr !== 8'h10) begin
      n_fail++;
      $display("[TB] FAIL t4_handshake: got valid=%b ready=%b adr=%h want 0/1/10",
               bus.rsp_valid, bus.req_ready, bus.ram_adr);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.ram_adr !== 8'h30 || bus.ram_wri !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL t4_resume: got adr=%h wri=%b ready=%b want 30/1/0",
               bus.ram_adr, bus.ram_wri, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_access();
    int acc;
    send(1'b1, 8'h42, 32'hA5A5A5A5, acc);
    @(negedge clk);
    n_cmp++; if (bus.ram_ena !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_in_act: ram_ena got %b want 1", bus.ram_ena); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ram_ena !== 1'b0 || bus.ram_adr !== 8'h42 || bus.ram_wri !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL t5_ena_fall: got ena=%b adr=%h wri=%b want 0/42/1", bus.ram_ena, bus.ram_adr, bus.ram_wri);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ram_adr !== 8'h0 || bus.ram_wri !== 1'b0 || bus.ram_wda !== 32'h0 || bus.ram_ena !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL t5_ram_cleared: got adr=%h wri=%b wda=%h ena=%b want 0/0/0/0",
               bus.ram_adr, bus.ram_wri, bus.ram_wda, bus.ram_ena);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rda !== 32'h0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL t5_rsp_cleared: got valid=%b rda=%h ready=%b want 0/0/0",
               bus.rsp_valid, bus.rsp_rda, bus.req_ready);
    end
    rst_n = 1'b1;
    do_read(8'h42, 32'hA5A5A5A5, "t5_read42");
  endtask

  task automatic test_idle();
    int p0, high_seen;
    repeat (4) @(negedge clk);
    p0 = pulses;
    high_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ram_ena !== 1'b0) high_seen++;
    end
    n_cmp++;
    if (high_seen !== 0 || pulses - p0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL t6_idle_ena: got %0d high samples %0d pulses want 0/0", high_seen, pulses - p0);
    end
    n_cmp++;
    if (mon_err !== 0) begin
      n_fail++;
      $display("[TB] FAIL adr_wri_stable: got %0d changes while ena high want 0", mon_err);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_adr = 8'h0; bus.req_wda = 32'h0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_boundary_addr();
    test_back_to_back();
    test_rsp_stall();
    repeat (8) @(negedge clk);
    test_reset_mid_access();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
